// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the memory wrapper and mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_done;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_done;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  owner;
  logic                  busy;
  logic                  err_rvalid;

  modport slave (
    input  if_req, if_addr,
    output if_done, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_done, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output owner, busy, err_rvalid
  );

  modport master (
    output if_req, if_addr,
    input  if_done, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_done, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  owner, busy, err_rvalid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage, one transaction at a time.
// Data wins arbitration, but a streak counter forces a fetch grant after MAX_DM_STREAK data grants.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [STREAK_W-1:0] r_streak, w_streak_nxt;
  logic                r_owner, w_owner_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_err, w_err_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [BE_W-1:0]     r_mem_be, w_mem_be_nxt;
  logic                r_if_done, w_if_done_nxt;
  logic                r_dm_done, w_dm_done_nxt;
  logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0]   r_dm_rdata, w_dm_rdata_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_owner     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_streak    <= w_streak_nxt;
      r_owner     <= w_owner_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_if_done   <= w_if_done_nxt;
      r_dm_done   <= w_dm_done_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_streak_nxt    = r_streak;
    w_owner_nxt     = r_owner;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_if_done_nxt   = 1'b0;
    w_dm_done_nxt   = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;
    // A response is only legal in WAIT; one arriving alongside mem_gnt lands in ISSUE and is flagged.
    w_err_nxt       = r_err | (bus.mem_rvalid && (r_state != WAIT));

    case (r_state)
      IDLE: begin
        if (bus.dm_req && (!bus.if_req || (r_streak < STREAK_MAX))) begin
          w_owner_nxt     = 1'b1;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = bus.dm_we;
          w_mem_addr_nxt  = bus.dm_addr;
          w_mem_wdata_nxt = bus.dm_wdata;
          w_mem_be_nxt    = bus.dm_be;
          w_state_nxt     = ISSUE;
          if (!bus.if_req) begin
            w_streak_nxt = '0;
          end else if (r_streak < STREAK_MAX) begin
            w_streak_nxt = r_streak + 1'b1;
          end
        end else if (bus.if_req) begin
          w_owner_nxt     = 1'b0;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = bus.if_addr;
          w_mem_wdata_nxt = '0;
          w_mem_be_nxt    = '1;
          w_streak_nxt    = '0;
          w_state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          w_state_nxt = RESP;
          if (r_owner) begin
            w_dm_done_nxt  = 1'b1;
            w_dm_rdata_nxt = r_mem_we ? '0 : bus.mem_rdata;
          end else begin
            w_if_done_nxt  = 1'b1;
            w_if_rdata_nxt = bus.mem_rdata;
          end
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.if_done    = r_if_done;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.dm_done    = r_dm_done;
  assign bus.dm_rdata   = r_dm_rdata;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_be     = r_mem_be;
  assign bus.owner      = r_owner;
  assign bus.busy       = r_busy;
  assign bus.err_rvalid = r_err;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: instruction fetch (read-only) and the memory stage (read/write).
- Sits between instruction_fetch_stage / memory_stage and the memory wrapper.
- Issues one memory transaction at a time, using a mem_req/mem_gnt request handshake and a mem_rvalid response.
- Data accesses have priority over fetch; a streak counter guarantees fetch progress.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width
MAX_DM_STREAK, 4, max consecutive data grants while fetch is waiting (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address; stable while if_req
if_done  out  1  one-cycle pulse, fetch complete
if_rdata  out  DATA_W  fetch data, valid when if_done
dm_req  in  1  data request; held until dm_done
dm_we  in  1  1 = write
dm_addr  in  ADDR_W  data address; stable while dm_req
dm_wdata  in  DATA_W  write data
dm_be  in  DATA_W/8  byte enables
dm_done  out  1  one-cycle pulse, data access complete
dm_rdata  out  DATA_W  read data, valid when dm_done; 0 for writes
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  response valid (reads and writes)
mem_rdata  in  DATA_W  response data
owner  out  1  0 = fetch, 1 = data; owner of current/last transaction
busy  out  1  state != IDLE
err_rvalid  out  1  sticky: mem_rvalid seen outside WAIT

Behaviour:
- All outputs are registered. Reset (rst=0, asynchronous) forces:
  - state IDLE, streak 0, err_rvalid 0.
  - every output 0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE arbitration, evaluated every cycle:
  - dm_req && (!if_req || streak < MAX_DM_STREAK): grant data.
  - else if if_req: grant fetch.
  - else stay in IDLE.
- On grant:
  - Latch request into mem_addr/mem_we/mem_wdata/mem_be.
  - Fetch grants drive mem_we=0, mem_be=all ones, mem_wdata=0.
  - Set owner; go to ISSUE.
- Streak counter update on each grant:
  - data grant with if_req=1: streak+1, saturating at MAX_DM_STREAK.
  - data grant with if_req=0: streak=0.
  - fetch grant: streak=0.
- ISSUE: mem_req=1, mem fields held stable. When mem_gnt=1, drop mem_req next cycle and go to WAIT. Any number of wait cycles is allowed.
- WAIT: wait for mem_rvalid; no timeout. On mem_rvalid, capture mem_rdata (forced to 0 if the transaction was a write) and go to RESP.
- mem_rvalid in the same cycle as mem_gnt is illegal. It is treated as outside WAIT (ignored, sets err_rvalid).
- RESP: pulse exactly one of if_done/dm_done (selected by owner), with rdata valid; go to IDLE.
  - if_rdata/dm_rdata hold their value until the next respective done.
- Requesters update address/req on the edge ending the done cycle. IDLE samples the new request one cycle later, so there are no duplicate grants.
- Minimum latency (req high while IDLE at cycle N, immediate gnt, rvalid one cycle after gnt): done at cycle N+3. Back-to-back throughput: one transaction per 4 cycles.
- A requester dropping req before done is illegal; the transaction completes regardless.
- Reset mid-transaction:
  - Immediate return to IDLE, mem_req=0, no done pulse.
  - A later stale mem_rvalid is ignored and sets err_rvalid.
- Address alignment is not checked; dm_be is passed through unchanged.

Test Plan:
1. if_req, if_addr=0x00000010; mem_gnt immediate; mem_rvalid next cycle with 0x00000013 -> mem_addr=0x10, mem_we=0, mem_be=0xF; if_done and if_rdata=0x00000013 exactly 3 cycles after req sampled; dm_done stays 0.
2. if_req and dm_req rise in the same cycle (dm read 0x100, memory returns 0xDEADBEEF) -> data served first: dm_done, dm_rdata=0xDEADBEEF, owner=1; then fetch served; each done pulses once.
3. dm_req continuously re-asserted after every done, if_req held -> exactly 4 data grants, then a fetch grant (owner=0), streak resets, data resumes.
4. Data write addr=0x200, wdata=0xA5A5A5A5, be=0x3; mem_gnt delayed 3 cycles -> mem_req held 4 cycles with fields stable; dm_done with dm_rdata=0; mem_we=1, mem_be=0x3.
5. rst=0 asserted while in WAIT for a fetch -> all outputs 0 immediately; after release, a stale mem_rvalid produces no if_done and sets err_rvalid=1, which stays 1 until reset.
6. mem_rvalid pulsed while IDLE with no requests -> no done pulses, err_rvalid=1, busy=0.
